mem_bus_arbiter: RTL and testbench

Shares one SRAM-like memory bus between the instruction-fetch requester (PC/IF stage) and the data requester (MEM stage).
- Grants one requester at a time and latches its request.
- Sequences the bus address and data handshakes.
- Returns read data and a one-cycle done pulse to the granted requester.
- Drives per-requester stall signals into the pipeline stall logic.
- Single outstanding transaction; sits between the core's IF/MEM stages and the bus bridge.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
`timescale 1ns/1ps
package mem_bus_arbiter_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on collisions using last_grant instead of fixed data priority.
`timescale 1ns/1ps
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic inst_elig,
  input  logic data_elig,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = inst_elig | data_elig;
    grant_sel   = SEL_INST;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the requester that was not served last goes first.
    if (inst_elig && data_elig)
      grant_sel = ~last_grant;
    else if (data_elig)
      grant_sel = SEL_DATA;
`else
    // Data wins ties so older instructions in MEM can drain ahead of fetch.
    if (data_elig)
      grant_sel = SEL_DATA;
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus between IF fetch and MEM data.
// ARB_ROUND_ROBIN_EN: enables round-robin tie breaking via a last_grant register.
`timescale 1ns/1ps
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_done,
  input  logic                  data_req,
  input  logic [3:0]            data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_done,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [3:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  stall_inst,
  output logic                  stall_data
);

  arb_state_t state;
  logic       sel;
  logic       inst_elig;
  logic       data_elig;
  logic       grant_valid;
  logic       grant_sel;
  logic       complete;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant;
`endif

  // A requester whose done pulse is high this cycle is not re-granted.
  assign inst_elig = inst_req & ~inst_done;
  assign data_elig = data_req & ~data_done;

  assign stall_inst = inst_req & ~inst_done;
  assign stall_data = data_req & ~data_done;

  assign complete = ((state == ADDR) && bus_addr_ok && bus_data_ok) ||
                    ((state == WAIT) && bus_data_ok);

  mem_arb_pick u_pick (
    .inst_elig   (inst_elig),
    .data_elig   (data_elig),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= SEL_INST;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= 4'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= SEL_INST;
`endif
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel       <= grant_sel;
            bus_req   <= 1'b1;
            bus_addr  <= (grant_sel == SEL_DATA) ? data_addr : inst_addr;
            bus_wstrb <= (grant_sel == SEL_DATA) ? data_we : 4'b0;
            bus_wdata <= (grant_sel == SEL_DATA) ? data_wdata : '0;
            bus_wr    <= (grant_sel == SEL_DATA) && (data_we != 4'b0);
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_sel;
`endif
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= bus_data_ok ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus_data_ok)
            state <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Write completions also capture bus_rdata; the requester ignores it.
      if (complete) begin
        if (sel == SEL_DATA) begin
          data_rdata <= bus_rdata;
          data_done  <= 1'b1;
        end else begin
          inst_rdata <= bus_rdata;
          inst_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stall_inst;
  logic        stall_data;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_inst(stall_inst), .stall_data(stall_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_we    = dwe;
    data_addr  = daddr;
    data_wdata = dwdata;
  endtask

  // Reference model: one transaction in flight, tracked as "owner" plus whether the address phase is over.
  bit          m_busy, m_addr_phase, m_owner_data, m_last_data;
  bit          m_req, m_wr, m_idone, m_ddone;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;

  task automatic modelFinish();
    if (m_owner_data) begin m_drdata = bus_rdata; m_ddone = 1'b1; end
    else begin m_irdata = bus_rdata; m_idone = 1'b1; end
    m_busy = 1'b0;
  endtask

  always @(posedge clk) begin
    bit want_i, want_d, pick_data;
    if (rst) begin
      m_busy = 0; m_addr_phase = 0; m_owner_data = 0; m_last_data = 0;
      m_req = 0; m_wr = 0; m_idone = 0; m_ddone = 0;
      m_wstrb = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
    end else begin
      want_i = inst_req && !m_idone;
      want_d = data_req && !m_ddone;
      m_idone = 0;
      m_ddone = 0;
      if (!m_busy) begin
        if (want_i || want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_data = (want_i && want_d) ? !m_last_data : want_d;
`else
          pick_data = want_d;
`endif
          m_last_data  = pick_data;
          m_busy       = 1;
          m_addr_phase = 1;
          m_owner_data = pick_data;
          m_req        = 1;
          m_addr       = pick_data ? data_addr : inst_addr;
          m_wstrb      = pick_data ? data_we : 4'b0;
          m_wdata      = pick_data ? data_wdata : 32'h0;
          m_wr         = pick_data && (data_we != 0);
        end
      end else if (m_addr_phase) begin
        if (bus_addr_ok) begin
          m_addr_phase = 0;
          m_req = 0;
          if (bus_data_ok) modelFinish();
        end
      end else if (bus_data_ok) begin
        modelFinish();
      end
    end
    #1;
    checkOutput("cyc_bus_req", bus_req, m_req);
    checkOutput("cyc_bus_wr", bus_wr, m_wr);
    checkOutput("cyc_bus_wstrb", bus_wstrb, m_wstrb);
    checkOutput("cyc_bus_addr", bus_addr, m_addr);
    checkOutput("cyc_bus_wdata", bus_wdata, m_wdata);
    checkOutput("cyc_inst_done", inst_done, m_idone);
    checkOutput("cyc_data_done", data_done, m_ddone);
    checkOutput("cyc_inst_rdata", inst_rdata, m_irdata);
    checkOutput("cyc_data_rdata", data_rdata, m_drdata);
    checkOutput("cyc_stall_inst", stall_inst, inst_req & ~m_idone);
    checkOutput("cyc_stall_data", stall_data, data_req & ~m_ddone);
  end

  // Waits (bounded) for bus_req, then drives the slave; returns in the done cycle.
  task automatic serve(input int addr_wait, input bit together, input logic [31:0] rd);
    int n = 0;
    while (!bus_req && n < 20) begin tick(); n++; end
    checkOutput("serve_bus_req_seen", bus_req, 1);
    repeat (addr_wait) tick();
    bus_addr_ok = 1; bus_data_ok = together; bus_rdata = rd;
    tick();
    bus_addr_ok = 0;
    if (!together) begin
      bus_data_ok = 1;
      tick();
    end
    bus_data_ok = 0;
    bus_rdata = 0;
  endtask

  initial begin
    logic [31:0] first_addr, second_addr;
    bit first_is_data;
    rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    repeat (3) tick();
    checkOutput("reset_bus_req", bus_req, 0);
    checkOutput("reset_bus_addr", bus_addr, 0);
    checkOutput("reset_inst_done", inst_done, 0);
    checkOutput("reset_data_rdata", data_rdata, 0);
    rst = 0;
    tick();

    $display("[TB] single fetch");
    applyStimulus(1, 32'hbfc00000, 0, 0, 0, 0);
    tick();
    checkOutput("fetch_bus_req_c1", bus_req, 1);
    checkOutput("fetch_bus_addr_c1", bus_addr, 32'hbfc00000);
    checkOutput("fetch_bus_wr_c1", bus_wr, 0);
    bus_addr_ok = 1;
    tick();
    checkOutput("fetch_bus_req_c2", bus_req, 0);
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h24080001;
    tick();
    bus_data_ok = 0; bus_rdata = 0;
    checkOutput("fetch_inst_done_c3", inst_done, 1);
    checkOutput("fetch_inst_rdata_c3", inst_rdata, 32'h24080001);
    checkOutput("fetch_stall_inst_c3", stall_inst, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("fetch_inst_done_c4", inst_done, 0);

    $display("[TB] store with delayed addr_ok");
    applyStimulus(0, 0, 1, 4'b0011, 32'h80000020, 32'hdeadbeef);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("store_bus_req", bus_req, 1);
      checkOutput("store_bus_addr", bus_addr, 32'h80000020);
      checkOutput("store_bus_wstrb", bus_wstrb, 4'b0011);
      checkOutput("store_bus_wdata", bus_wdata, 32'hdeadbeef);
      checkOutput("store_bus_wr", bus_wr, 1);
      bus_addr_ok = (i == 3);
      tick();
    end
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678;
    tick();
    bus_data_ok = 0; bus_rdata = 0;
    checkOutput("store_data_done", data_done, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("store_data_done_once", data_done, 0);

    $display("[TB] collision");
`ifdef ARB_ROUND_ROBIN_EN
    first_is_data = 0;
`else
    first_is_data = 1;
`endif
    first_addr  = first_is_data ? 32'h80000010 : 32'hbfc00004;
    second_addr = first_is_data ? 32'hbfc00004 : 32'h80000010;
    applyStimulus(1, 32'hbfc00004, 1, 0, 32'h80000010, 0);
    tick();
    checkOutput("collide_first_addr", bus_addr, first_addr);
    serve(0, 0, 32'h11111111);
    if (first_is_data) begin
      checkOutput("collide_data_done", data_done, 1);
      checkOutput("collide_data_rdata", data_rdata, 32'h11111111);
      applyStimulus(1, 32'hbfc00004, 0, 0, 0, 0);
    end else begin
      checkOutput("collide_inst_done", inst_done, 1);
      checkOutput("collide_inst_rdata", inst_rdata, 32'h11111111);
      applyStimulus(0, 0, 1, 0, 32'h80000010, 0);
    end
    tick();
    checkOutput("collide_second_req", bus_req, 1);
    checkOutput("collide_second_addr", bus_addr, second_addr);
    serve(0, 0, 32'h22222222);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] same-cycle handshake");
    applyStimulus(1, 32'hbfc00008, 0, 0, 0, 0);
    tick();
    serve(0, 1, 32'hcafef00d);
    checkOutput("same_inst_done", inst_done, 1);
    checkOutput("same_inst_rdata", inst_rdata, 32'hcafef00d);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("same_no_second_req", bus_req, 0);
    checkOutput("same_done_cleared", inst_done, 0);

    $display("[TB] reset mid-transaction");
    applyStimulus(0, 0, 1, 0, 32'h80000040, 0);
    tick();
    bus_addr_ok = 1;
    tick();
    bus_addr_ok = 0;
    rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_data_done", data_done, 0);
    checkOutput("rst_data_rdata", data_rdata, 0);
    checkOutput("rst_inst_rdata", inst_rdata, 0);
    rst = 0;
    bus_data_ok = 1; bus_rdata = 32'h55555555;
    tick();
    bus_data_ok = 0; bus_rdata = 0;
    checkOutput("rst_late_data_ok", data_done, 0);
    tick();

    $display("[TB] back-to-back fetches");
    applyStimulus(1, 32'hbfc00010, 0, 0, 0, 0);
    tick();
    serve(0, 0, 32'haaaa0001);
    checkOutput("b2b_first_done", inst_done, 1);
    applyStimulus(1, 32'hbfc00014, 0, 0, 0, 0);
    tick();
    checkOutput("b2b_no_dup_grant", bus_req, 0);
    tick();
    checkOutput("b2b_second_req", bus_req, 1);
    checkOutput("b2b_second_addr", bus_addr, 32'hbfc00014);
    serve(1, 0, 32'haaaa0002);
    checkOutput("b2b_second_rdata", inst_rdata, 32'haaaa0002);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

endmodule
